ysyx_22040632_mul: RTL

Multi-cycle RV64M multiplier, the responder on the EXU's request/response handshake alongside the divider. It covers MUL, MULH, MULHSU, MULHU and MULW. The EXU issues operands and an operation type, then stalls until the result is returned. The core is a radix-2 shift-add datapath with sign fix-up, and only one operation is in flight at a time.

---
 rtl/ysyx_22040632_mul.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22040632_mul.sv
// Multi-cycle RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW), radix-2 shift-add with sign fix-up.
// Optional early exit on an exhausted multiplier: define YSYX_22040632_MUL_EARLY_EXIT_EN.
module ysyx_22040632_mul #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mul_valid,
   output logic            mul_ready,
   input  logic            flush,
   input  logic            mulw,
   input  logic [1:0]      mul_signed,
   input  logic [XLEN-1:0] multiplicand,
   input  logic [XLEN-1:0] multiplier,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_hi,
   output logic [XLEN-1:0] result_lo,
   output logic [1:0]      dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   // Handshake: a request transfers on a rising edge with mul_valid & mul_ready & !flush;
   // a result transfers on a rising edge with out_valid & out_ready & !flush.

   logic [1:0]   state_q, state_d;
   logic [63:0]  mcand_q, mcand_d;
   logic [63:0]  mplier_q, mplier_d;
   logic [127:0] acc_q, acc_d;
   logic [6:0]   cnt_q, cnt_d;
   logic         mulw_q, mulw_d;
   logic         neg_q, neg_d;
   logic [63:0]  res_hi_q, res_hi_d;
   logic [63:0]  res_lo_q, res_lo_d;

   logic         a_neg, b_neg;
   logic [64:0]  sum;
   logic [128:0] acc_wide;
   logic [6:0]   n_iter;
   logic         busy_done;
   logic [127:0] prod_abs, prod;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mulw_d   = mulw_q;
      neg_d    = neg_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;

      a_neg = !mulw & mul_signed[1] & multiplicand[63];
      b_neg = !mulw & (mul_signed == 2'b11) & multiplier[63];

      // Carry out of the upper-half add lands in bit 128 before the right shift.
      sum      = {1'b0, acc_q[127:64]} + (mplier_q[0] ? {1'b0, mcand_q} : 65'd0);
      acc_wide = {sum, acc_q[63:0]};

      n_iter = mulw_q ? 7'd32 : 7'd64;
`ifdef YSYX_22040632_MUL_EARLY_EXIT_EN
      busy_done = (cnt_q == n_iter) || (mplier_q == 64'd0);
`else
      busy_done = (cnt_q == n_iter);
`endif

      // After c iterations the product sits at acc << (64 - c); this also
      // realigns an early-exited accumulator in one step.
      prod_abs = acc_q >> (7'd64 - cnt_q);
      prod     = neg_q ? (128'd0 - prod_abs) : prod_abs;

      case (state_q)
         IDLE: begin
            if (mul_valid && !flush) begin
               if (mulw) begin
                  mcand_d  = {32'd0, multiplicand[31:0]};
                  mplier_d = {32'd0, multiplier[31:0]};
               end else begin
                  mcand_d  = a_neg ? (64'd0 - multiplicand) : multiplicand;
                  mplier_d = b_neg ? (64'd0 - multiplier) : multiplier;
               end
               neg_d   = a_neg ^ b_neg;
               mulw_d  = mulw;
               acc_d   = 128'd0;
               cnt_d   = 7'd0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (busy_done) begin
               state_d = FIX;
            end else begin
               acc_d    = acc_wide[128:1];
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 7'd1;
            end
         end
         FIX: begin
            if (mulw_q) begin
               res_lo_d = {{32{prod[31]}}, prod[31:0]};
               res_hi_d = 64'd0;
            end else begin
               res_lo_d = prod[63:0];
               res_hi_d = prod[127:64];
            end
            state_d = DONE;
         end
         default: begin
            if (out_ready) state_d = IDLE;
         end
      endcase

      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= 64'd0;
         mplier_q <= 64'd0;
         acc_q    <= 128'd0;
         cnt_q    <= 7'd0;
         mulw_q   <= 1'b0;
         neg_q    <= 1'b0;
         res_hi_q <= 64'd0;
         res_lo_q <= 64'd0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mulw_q   <= mulw_d;
         neg_q    <= neg_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end

   assign mul_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result_hi = res_hi_q;
   assign result_lo = res_lo_q;
   assign dbg_state = state_q;

endmodule
